frame_sequencer: RTL
====================

# frame_sequencer

Frame-level sequencer directly downstream of the 12-bit pixel/line counter. It drives the counter's enable (`b12_enb`), consumes its `endLine` pulse, and counts lines per frame. It inserts horizontal and vertical blanking intervals and flags frame boundaries to the pattern generators. One frame runs per `run` request; frames repeat back-to-back while `run` stays high.

## Interface
- `LINES` — default 1024 — active lines per frame, normal mode
- `LINES_TEST` — default 4 — active lines per frame, test mode
- `HBLANK` — default 16 — blanking cycles after each line (≥1)
- `VBLANK` — default 32 — blanking cycles after the last line of a frame (≥1)
- `clk`  in  1  16 ns master clock
- `rst`  in  1  synchronous reset, active high
- `run`  in  1  level; high = generate frames continuously
- `test`  in  1  '1' test mode, '0' normal mode; sampled at frame start only
- `endLine`  in  1  end-of-line from the pixel counter; ignored outside ACTIVE
- `b12_enb`  out  1  pixel counter enable; high only in ACTIVE
- `line_cnt`  out  11  index of the current line, 0-based
- `hblank`  out  1  high in HBLANK
- `vblank`  out  1  high in VBLANK
- `endFrame`  out  1  one-cycle pulse when the frame's last line completes
- `busy`  out  1  high in any state except IDLE

## Operation
- The single clock is `clk`. Reset is `rst`: synchronous and active high.
- States are IDLE, ACTIVE, HBLANK and VBLANK. All outputs are registered.
- Reset puts the block in IDLE. `b12_enb`, `hblank`, `vblank`, `endFrame` and `busy` reset to 0; `line_cnt` resets to 0. Reset overrides everything, mid-frame included.
- **IDLE:**
  - `run`=1 moves to ACTIVE and latches `test` into `test_q`.
  - The last-line index becomes `LINES_TEST`-1 if `test_q`=1, else `LINES`-1.
  - `line_cnt` is set to 0.
- **ACTIVE:**
  - `b12_enb`=1.
  - `endLine`=1 with `line_cnt` < last moves to HBLANK.
  - `endLine`=1 with `line_cnt` == last moves to VBLANK and pulses `endFrame` on the same edge.
- **HBLANK:**
  - A blank counter loads `HBLANK`-1 on entry and decrements each cycle.
  - When it reaches 0, `line_cnt` increments by 1 and the block returns to ACTIVE.
- **VBLANK:**
  - The blank counter loads `VBLANK`-1 on entry and decrements each cycle.
  - At 0 with `run`=1: go to ACTIVE, set `line_cnt`=0 and re-latch `test`.
  - At 0 with `run`=0: go to IDLE and set `line_cnt`=0.
- Dropping `run` mid-frame does not abort the frame. The frame completes, including VBLANK, then the block goes to IDLE.
- A change on `test` mid-frame has no effect until the next frame start.
- `endLine` seen in IDLE, HBLANK or VBLANK is ignored. No state or counter changes.
- `line_cnt` is held through HBLANK and VBLANK and never exceeds last.

## Timing
- `b12_enb` rises on the edge that enters ACTIVE, one cycle after `run` is sampled high in IDLE.
- `endLine` is sampled at edge E. At E, ACTIVE is left and `b12_enb`=0 from E onward. The pixel counter therefore clears at E+1.
- An ACTIVE period lasts N+1 cycles when the counter's terminal count is N.
- HBLANK lasts exactly `HBLANK` cycles. VBLANK lasts exactly `VBLANK` cycles.
- `endFrame` is high for exactly the first cycle of VBLANK.
- Line period = ACTIVE + `HBLANK`. Frame end to next ACTIVE = `VBLANK` cycles.

## Structure
- Shared package `patterns_pkg`:
  - state encoding constants `FS_IDLE`, `FS_ACTIVE`, `FS_HBLANK`, `FS_VBLANK` (2 bits)
  - default line and blank constants
- The blank-interval counter is a natural sub-module. Name it `blank_timer`: load, decrement, `done` flag, 6-bit width.
- The rest of the block is a single FSM with the line counter.

## Test plan
- `rst` asserted for 3 cycles mid-ACTIVE on line 2 -> the next cycle is IDLE with all outputs 0 and `line_cnt`=0. The pixel counter stops because `b12_enb`=0.
- `test`=1, `run` pulsed high 1 cycle, pixel counter terminal 1289 -> exactly 4 ACTIVE periods of 1290 cycles each, with 16-cycle HBLANK gaps between them. `endFrame` pulses once, then 32 VBLANK cycles, then IDLE.
- `run` held high, `test`=0 -> `line_cnt` runs 0..1023 and `endFrame` pulses every frame. ACTIVE restarts exactly 32 cycles after `endFrame` with `line_cnt`=0.
- `test` toggled 0→1 during line 5 of a normal frame -> the frame still ends after line 1023. The next frame (`run`=1) ends after line 3.
- `endLine` forced high during HBLANK and VBLANK -> no change in state, `line_cnt`, or blank timing.
- `run` dropped during line 10 -> the frame completes all lines plus VBLANK, then IDLE. `busy` falls on the edge that enters IDLE.

Source files
------------

// File: rtl/patterns_pkg.sv
// Shared types and defaults for the frame-level pattern sequencing blocks.
package patterns_pkg;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_ACTIVE = 2'd1,
        FS_HBLANK = 2'd2,
        FS_VBLANK = 2'd3
    } fs_state_e;

    localparam int LINE_W       = 11;
    localparam int BLANK_W      = 6;
    localparam int DEF_LINES    = 1024;
    localparam int DEF_LINES_TS = 4;
    localparam int DEF_HBLANK   = 16;
    localparam int DEF_VBLANK   = 32;

endpackage

// File: rtl/frame_sequencer_if.sv
// Handshake between the frame sequencer and its controller / pixel counter.
interface frame_sequencer_if;
    import patterns_pkg::*;

    logic              run;
    logic              test;
    logic              endLine;
    logic              b12_enb;
    logic [LINE_W-1:0] line_cnt;
    logic              hblank;
    logic              vblank;
    logic              endFrame;
    logic              busy;

    modport master (
        output run, test, endLine,
        input  b12_enb, line_cnt, hblank, vblank, endFrame, busy
    );

    modport slave (
        input  run, test, endLine,
        output b12_enb, line_cnt, hblank, vblank, endFrame, busy
    );

endinterface

// File: rtl/blank_timer.sv
// Down-counter timing the horizontal and vertical blanking intervals.
module blank_timer
    import patterns_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [BLANK_W-1:0] val_i,
    output logic               done_o
);

    logic [BLANK_W-1:0] cnt_q;
    logic [BLANK_W-1:0] cnt_d;

    // Saturates at zero so done stays asserted while the FSM is elsewhere.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: gates the pixel counter, counts lines and inserts blanking.
module frame_sequencer
    import patterns_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINES_TEST = DEF_LINES_TS,
    parameter int HBLANK     = DEF_HBLANK,
    parameter int VBLANK     = DEF_VBLANK
) (
    input  logic               clk,
    input  logic               rst,
    frame_sequencer_if.slave   bus
);

    fs_state_e          state_q;
    logic               test_q;
    logic [LINE_W-1:0]  line_cnt_q;
    logic               b12_enb_q;
    logic               hblank_q;
    logic               vblank_q;
    logic               endFrame_q;
    logic               busy_q;

    logic [LINE_W-1:0]  last_line;
    logic               is_last;
    logic               tmr_load;
    logic [BLANK_W-1:0] tmr_val;
    logic               tmr_done;

    assign last_line = test_q ? LINE_W'(LINES_TEST - 1) : LINE_W'(LINES - 1);
    assign is_last   = (line_cnt_q == last_line);

    // The timer must load on the same edge that leaves ACTIVE, so this stays combinational.
    assign tmr_load = (state_q == FS_ACTIVE) && bus.endLine;
    assign tmr_val  = is_last ? BLANK_W'(VBLANK - 1) : BLANK_W'(HBLANK - 1);

    blank_timer u_blank_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .done_o (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_IDLE;
            test_q     <= 1'b0;
            line_cnt_q <= '0;
            b12_enb_q  <= 1'b0;
            hblank_q   <= 1'b0;
            vblank_q   <= 1'b0;
            endFrame_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            endFrame_q <= 1'b0;
            case (state_q)
                FS_IDLE: begin
                    if (bus.run) begin
                        state_q    <= FS_ACTIVE;
                        test_q     <= bus.test;
                        line_cnt_q <= '0;
                        b12_enb_q  <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                FS_ACTIVE: begin
                    if (bus.endLine) begin
                        b12_enb_q <= 1'b0;
                        if (is_last) begin
                            state_q    <= FS_VBLANK;
                            vblank_q   <= 1'b1;
                            endFrame_q <= 1'b1;
                        end else begin
                            state_q  <= FS_HBLANK;
                            hblank_q <= 1'b1;
                        end
                    end
                end
                FS_HBLANK: begin
                    if (tmr_done) begin
                        state_q    <= FS_ACTIVE;
                        hblank_q   <= 1'b0;
                        b12_enb_q  <= 1'b1;
                        line_cnt_q <= line_cnt_q + 1'b1;
                    end
                end
                FS_VBLANK: begin
                    if (tmr_done) begin
                        vblank_q   <= 1'b0;
                        line_cnt_q <= '0;
                        if (bus.run) begin
                            state_q   <= FS_ACTIVE;
                            test_q    <= bus.test;
                            b12_enb_q <= 1'b1;
                        end else begin
                            state_q <= FS_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= FS_IDLE;
            endcase
        end
    end

    assign bus.b12_enb  = b12_enb_q;
    assign bus.line_cnt = line_cnt_q;
    assign bus.hblank   = hblank_q;
    assign bus.vblank   = vblank_q;
    assign bus.endFrame = endFrame_q;
    assign bus.busy     = busy_q;

endmodule
